// File: rtl/sum_checker_if.sv
// Operand/result stream into the adder response checker.
// The producer drives a/b/s with in_valid; the checker answers with in_ready.
interface sum_checker_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] s;

   modport master (
      output in_valid,
      output a,
      output b,
      output s,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  s,
      output in_ready
   );
endinterface

// File: rtl/sum_checker.sv
// Sequential response checker for the adder datapath.
// Accepts (a, b, s) triples, recomputes a + b in a two-stage pipeline,
// counts mismatches, latches the first failing vector and reports
// pass/done once the programmed number of vectors has been checked.
module sum_checker #(
   parameter int WIDTH       = 32,
   parameter int NUM_VECTORS = 10,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   sum_checker_if.slave     in_if,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] fail_idx,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH-1:0] fail_s,
   output logic [WIDTH-1:0] fail_exp
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Index of the transfer that completes a run.
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_r;
   state_t           state_next_s;
   logic             start_run_s;
   logic             xfer_s;
   logic [WIDTH-1:0] exp_s;

   logic             in_ready_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [CNT_W-1:0] vec_count_r;
   logic [CNT_W-1:0] err_count_r;

   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_a_r;
   logic [WIDTH-1:0] s1_b_r;
   logic [WIDTH-1:0] s1_s_r;
   logic [CNT_W-1:0] s1_idx_r;

   logic             s2_valid_r;
   logic             s2_mis_r;
   logic [WIDTH-1:0] s2_a_r;
   logic [WIDTH-1:0] s2_b_r;
   logic [WIDTH-1:0] s2_s_r;
   logic [WIDTH-1:0] s2_exp_r;
   logic [CNT_W-1:0] s2_idx_r;

   logic             fail_seen_r;
   logic [CNT_W-1:0] fail_idx_r;
   logic [WIDTH-1:0] fail_a_r;
   logic [WIDTH-1:0] fail_b_r;
   logic [WIDTH-1:0] fail_s_r;
   logic [WIDTH-1:0] fail_exp_r;

   // in_ready_r mirrors "state is RUN", so a transfer is valid && ready.
   assign xfer_s = in_if.in_valid && in_ready_r;
   // Expected sum; the carry out is intentionally dropped (mod 2^WIDTH).
   assign exp_s  = s1_a_r + s1_b_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; start is honoured only from IDLE or DONE.
   always_comb begin
      state_next_s = state_r;
      start_run_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_RUN;
               start_run_s  = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (xfer_s && (vec_count_r == LAST_IDX)) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!s1_valid_r && !s2_valid_r) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_next_s = ST_RUN;
               start_run_s  = 1'b1;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Registered status outputs, derived from the upcoming state.
   // err_count is already final when DONE is entered (pipeline is empty).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
      end else begin
         in_ready_r <= (state_next_s == ST_RUN);
         busy_r     <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
         done_r     <= (state_next_s == ST_DONE);
         pass_r     <= (state_next_s == ST_DONE) && (err_count_r == {CNT_W{1'b0}});
      end
   end

   // Accepted-vector counter; it also numbers the vectors for fail_idx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_count_r <= {CNT_W{1'b0}};
      end else if (start_run_s) begin
         vec_count_r <= {CNT_W{1'b0}};
      end else if (xfer_s) begin
         vec_count_r <= vec_count_r + CNT_ONE;
      end else begin
         vec_count_r <= vec_count_r;
      end
   end

   // Stage 1: capture the handshaken triple and its index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= {WIDTH{1'b0}};
         s1_b_r     <= {WIDTH{1'b0}};
         s1_s_r     <= {WIDTH{1'b0}};
         s1_idx_r   <= {CNT_W{1'b0}};
      end else begin
         s1_valid_r <= xfer_s;
         if (xfer_s) begin
            s1_a_r   <= in_if.a;
            s1_b_r   <= in_if.b;
            s1_s_r   <= in_if.s;
            s1_idx_r <= vec_count_r;
         end else begin
            s1_a_r   <= s1_a_r;
            s1_b_r   <= s1_b_r;
            s1_s_r   <= s1_s_r;
            s1_idx_r <= s1_idx_r;
         end
      end
   end

   // Stage 2: register the expected sum and the compare result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_mis_r   <= 1'b0;
         s2_a_r     <= {WIDTH{1'b0}};
         s2_b_r     <= {WIDTH{1'b0}};
         s2_s_r     <= {WIDTH{1'b0}};
         s2_exp_r   <= {WIDTH{1'b0}};
         s2_idx_r   <= {CNT_W{1'b0}};
      end else begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_mis_r <= (exp_s != s1_s_r);
            s2_a_r   <= s1_a_r;
            s2_b_r   <= s1_b_r;
            s2_s_r   <= s1_s_r;
            s2_exp_r <= exp_s;
            s2_idx_r <= s1_idx_r;
         end else begin
            s2_mis_r <= 1'b0;
            s2_a_r   <= s2_a_r;
            s2_b_r   <= s2_b_r;
            s2_s_r   <= s2_s_r;
            s2_exp_r <= s2_exp_r;
            s2_idx_r <= s2_idx_r;
         end
      end
   end

   // Saturating mismatch counter, updated the cycle after stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_r <= {CNT_W{1'b0}};
      end else if (start_run_s) begin
         err_count_r <= {CNT_W{1'b0}};
      end else if (s2_valid_r && s2_mis_r && (err_count_r != CNT_MAX)) begin
         err_count_r <= err_count_r + CNT_ONE;
      end else begin
         err_count_r <= err_count_r;
      end
   end

   // First-fail capture: only the first mismatch of a run is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_seen_r <= 1'b0;
         fail_idx_r  <= {CNT_W{1'b0}};
         fail_a_r    <= {WIDTH{1'b0}};
         fail_b_r    <= {WIDTH{1'b0}};
         fail_s_r    <= {WIDTH{1'b0}};
         fail_exp_r  <= {WIDTH{1'b0}};
      end else if (start_run_s) begin
         fail_seen_r <= 1'b0;
         fail_idx_r  <= {CNT_W{1'b0}};
         fail_a_r    <= {WIDTH{1'b0}};
         fail_b_r    <= {WIDTH{1'b0}};
         fail_s_r    <= {WIDTH{1'b0}};
         fail_exp_r  <= {WIDTH{1'b0}};
      end else if (s2_valid_r && s2_mis_r && !fail_seen_r) begin
         fail_seen_r <= 1'b1;
         fail_idx_r  <= s2_idx_r;
         fail_a_r    <= s2_a_r;
         fail_b_r    <= s2_b_r;
         fail_s_r    <= s2_s_r;
         fail_exp_r  <= s2_exp_r;
      end else begin
         fail_seen_r <= fail_seen_r;
         fail_idx_r  <= fail_idx_r;
         fail_a_r    <= fail_a_r;
         fail_b_r    <= fail_b_r;
         fail_s_r    <= fail_s_r;
         fail_exp_r  <= fail_exp_r;
      end
   end

   assign in_if.in_ready = in_ready_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign vec_count      = vec_count_r;
   assign err_count      = err_count_r;
   assign fail_idx       = fail_idx_r;
   assign fail_a         = fail_a_r;
   assign fail_b         = fail_b_r;
   assign fail_s         = fail_s_r;
   assign fail_exp       = fail_exp_r;

endmodule

// File: tb/tb_sum_checker.sv
// Bench for sum_checker: directed runs plus a transaction-level model that
// predicts every output on every cycle from the accepted-vector history.
module tb_sum_checker;

   localparam int W = 32;
   localparam int N = 10;
   localparam int C = 16;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         busy;
   logic         done;
   logic         pass;
   logic [C-1:0] vec_count;
   logic [C-1:0] err_count;
   logic [C-1:0] fail_idx;
   logic [W-1:0] fail_a;
   logic [W-1:0] fail_b;
   logic [W-1:0] fail_s;
   logic [W-1:0] fail_exp;

   sum_checker_if #(.WIDTH(W)) bus ();

   sum_checker #(.WIDTH(W), .NUM_VECTORS(N), .CNT_W(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_if     (bus),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .vec_count (vec_count),
      .err_count (err_count),
      .fail_idx  (fail_idx),
      .fail_a    (fail_a),
      .fail_b    (fail_b),
      .fail_s    (fail_s),
      .fail_exp  (fail_exp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A run is described by the list of accepted triples and the cycle at
   // which each was accepted; every output follows from that list.
   typedef struct {
      int         cyc;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
   } rec_t;

   rec_t q[$];
   bit   run_on = 1'b0;
   int   cyc    = 0;

   function automatic bit m_done();
      if (run_on && q.size() == N)
         return (cyc >= q[q.size()-1].cyc + 3);
      return 1'b0;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            run_on = 1'b0;
            q.delete();
         end else begin
            bit rdy;
            bit dn;
            rdy = run_on && (q.size() < N);
            dn  = m_done();
            cyc++;
            if (rdy && bus.in_valid)
               q.push_back('{cyc, bus.a, bus.b, bus.s});
            if (start && (!run_on || dn)) begin
               run_on = 1'b1;
               q.delete();
            end
         end
      end
   end

   // Compare every output against the model on each falling edge.
   initial begin
      forever begin
         @(negedge clk);
         begin
            int           e_err;
            bit           found;
            logic [C-1:0] e_idx;
            logic [W-1:0] e_a, e_b, e_s, e_x, sum;
            bit           e_done;
            e_err = 0; found = 1'b0;
            e_idx = 16'd0; e_a = 32'd0; e_b = 32'd0; e_s = 32'd0; e_x = 32'd0;
            foreach (q[i]) begin
               if (q[i].cyc <= cyc - 2) begin
                  sum = q[i].a + q[i].b;
                  if (sum != q[i].s) begin
                     if (!found) begin
                        found = 1'b1;
                        e_idx = C'(i);
                        e_a = q[i].a; e_b = q[i].b; e_s = q[i].s; e_x = sum;
                     end
                     e_err++;
                  end
               end
            end
            e_done = m_done();
            check("m_in_ready", bus.in_ready, run_on && (q.size() < N));
            check("m_busy", busy, run_on && !e_done);
            check("m_done", done, e_done);
            check("m_pass", pass, e_done && (e_err == 0));
            check("m_vec_count", vec_count, q.size());
            check("m_err_count", err_count, e_err);
            check("m_fail_idx", fail_idx, e_idx);
            check("m_fail_a", fail_a, e_a);
            check("m_fail_b", fail_b, e_b);
            check("m_fail_s", fail_s, e_s);
            check("m_fail_exp", fail_exp, e_x);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
      bit rdy;
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.s = s;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      if (!ok) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!ok) check("done_timeout", 64'd0, 64'd1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      rst_n = 1'b0; start = 1'b0;
      bus.in_valid = 1'b0; bus.a = 32'd0; bus.b = 32'd0; bus.s = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: reset in the middle of a run
      pulse_start();
      for (int i = 0; i < 4; i++) send(32'd1, 32'd2, 32'd3);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_vec_count", vec_count, 16'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      check("restart_vec_count", vec_count, 16'd0);
      check("restart_in_ready", bus.in_ready, 1'b1);

      // 2: ten correct triples back-to-back
      send(32'h0000_0005, 32'h0000_0007, 32'h0000_000C);
      for (int i = 1; i < N; i++) send(32'(5 + i), 32'(7 * i), 32'(5 + i + 7 * i));
      check("t2_ready_drop", bus.in_ready, 1'b0);
      check("t2_vec_count", vec_count, 16'd10);
      repeat (2) @(posedge clk);
      #1 check("t2_done_early", done, 1'b0);
      @(posedge clk);
      #1 check("t2_done_at_3", done, 1'b1);
      check("t2_err_count", err_count, 16'd0);
      check("t2_pass", pass, 1'b1);

      // 3: vectors 3 and 7 wrong
      idle(2);
      pulse_start();
      for (int i = 0; i < N; i++) begin
         if (i == 3) send(32'h10, 32'h20, 32'h31);
         else if (i == 7) send(32'h7, 32'h8, 32'h0);
         else send(32'(i), 32'(3 * i), 32'(4 * i));
      end
      bus.in_valid = 1'b0;
      wait_done();
      check("t3_err_count", err_count, 16'd2);
      check("t3_fail_idx", fail_idx, 16'd3);
      check("t3_fail_a", fail_a, 32'h10);
      check("t3_fail_b", fail_b, 32'h20);
      check("t3_fail_s", fail_s, 32'h31);
      check("t3_fail_exp", fail_exp, 32'h30);
      check("t3_pass", pass, 1'b0);

      // 4: overflow vectors
      pulse_start();
      send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      for (int i = 3; i < N; i++) send(32'h8000_0000, 32'h8000_0000, 32'h0);
      bus.in_valid = 1'b0;
      wait_done();
      check("t4_err_count", err_count, 16'd1);
      check("t4_fail_idx", fail_idx, 16'd1);
      check("t4_fail_s", fail_s, 32'h0000_0001);
      check("t4_fail_exp", fail_exp, 32'h0000_0000);

      // 5: gaps between vectors, random errors, traffic while not ready
      pulse_start();
      for (int i = 0; i < N; i++) begin
         logic [W-1:0] ra, rb;
         idle($urandom_range(0, 3));
         ra = $urandom; rb = $urandom;
         send(ra, rb, ra + rb + W'($urandom_range(0, 3) == 0));
      end
      bus.a = 32'hDEAD_BEEF; bus.b = 32'h1; bus.s = 32'h2;
      repeat (2) @(posedge clk);
      #1;
      check("t5_not_consumed", vec_count, 16'd10);
      bus.in_valid = 1'b0;
      wait_done();

      // 6: start during RUN is ignored, start in DONE restarts
      pulse_start();
      for (int i = 0; i < 3; i++) send(32'd2, 32'd2, 32'd5);
      bus.in_valid = 1'b0;
      pulse_start();
      check("t6_ignored_vec", vec_count, 16'd3);
      for (int i = 3; i < N; i++) send(32'd2, 32'd2, 32'd4);
      bus.in_valid = 1'b0;
      wait_done();
      check("t6_err_count", err_count, 16'd3);
      pulse_start();
      check("t6_clr_vec", vec_count, 16'd0);
      check("t6_clr_err", err_count, 16'd0);
      check("t6_clr_fail_idx", fail_idx, 16'd0);
      check("t6_clr_fail_s", fail_s, 32'd0);
      check("t6_busy", busy, 1'b1);
      for (int i = 0; i < N; i++) send(32'(i), 32'(i), 32'(2 * i));
      bus.in_valid = 1'b0;
      wait_done();
      check("t6_pass", pass, 1'b1);

      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
